time_display_driver: RTL and testbench



---
 rtl/time_display_driver.sv | 160 ++++++++++++++++
 tb/tb_time_display_driver.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_display_driver.sv
// Snapshots min/sec/ms once per display frame, converts them to BCD with a serial
// double-dabble FSM, and scans a 4-digit active-low 7-segment display (MM.SS or SS.hh).
module time_display_driver #(
   parameter int SCAN_DIV   = 1000,
   parameter int LEAD_BLANK = 1
) (
   input  logic       clk_high_speed,
   input  logic       rst_n,
   input  logic [9:0] time_ms,
   input  logic [5:0] time_sec,
   input  logic [5:0] time_min,
   input  logic       disp_mode,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       conv_busy
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [2:0] {IDLE, CONV_MIN, CONV_SEC, CONV_MS, COMMIT} state_t;

   state_t      state, state_nxt;
   logic [PW-1:0] presc;
   logic [1:0]  idx;
   logic        tc, frame_start, last;
   logic [3:0]  cnt;
   logic [9:0]  sh, ms_clamped;
   logic [11:0] bcd, adj, step;
   logic [5:0]  snap_sec;
   logic [9:0]  snap_ms;
   logic        snap_mode;
   logic [7:0]  pend_min, pend_sec, pend_ms;
   logic [3:0]  min_t, min_o, sec_t, sec_o, ms_h, ms_t;
   logic        mode;
   logic [3:0]  digit;

   assign tc          = (presc == PW'(SCAN_DIV - 1));
   assign frame_start = tc && (idx == 2'd3);
   assign ms_clamped  = (time_ms > 10'd999) ? 10'd999 : time_ms;

   always_ff @(posedge clk_high_speed) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= 2'd0;
      end else if (tc) begin
         presc <= '0;
         idx   <= idx + 2'd1;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift in the next binary bit.
   always_comb begin
      adj = bcd;
      for (int i = 0; i < 3; i++)
         if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
      step = {adj[10:0], sh[9]};
   end

   always_comb begin
      case (state)
         CONV_MIN, CONV_SEC: last = (cnt == 4'd5);
         CONV_MS:            last = (cnt == 4'd9);
         default:            last = 1'b0;
      endcase
   end

   always_ff @(posedge clk_high_speed) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (frame_start) state_nxt = CONV_MIN;
         CONV_MIN: if (last) state_nxt = CONV_SEC;
         CONV_SEC: if (last) state_nxt = CONV_MS;
         CONV_MS:  if (last) state_nxt = COMMIT;
         COMMIT:   state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      conv_busy = (state != IDLE);
   end

   // Results land in pend_* and only reach the displayed registers at COMMIT, so a frame never tears.
   always_ff @(posedge clk_high_speed) begin
      if (!rst_n) begin
         cnt <= 4'd0;  sh <= '0;  bcd <= '0;
         snap_sec <= '0;  snap_ms <= '0;  snap_mode <= 1'b0;
         pend_min <= '0;  pend_sec <= '0;  pend_ms <= '0;
         min_t <= '0;  min_o <= '0;  sec_t <= '0;  sec_o <= '0;  ms_h <= '0;  ms_t <= '0;
         mode <= 1'b0;
      end else begin
         case (state)
            IDLE: if (frame_start) begin
               snap_sec  <= time_sec;
               snap_ms   <= ms_clamped;
               snap_mode <= disp_mode;
               sh        <= {time_min, 4'b0000};
               bcd       <= '0;
               cnt       <= 4'd0;
            end
            CONV_MIN, CONV_SEC, CONV_MS: begin
               if (last) begin
                  cnt <= 4'd0;
                  bcd <= '0;
                  case (state)
                     CONV_MIN: begin pend_min <= step[7:0]; sh <= {snap_sec, 4'b0000}; end
                     CONV_SEC: begin pend_sec <= step[7:0]; sh <= snap_ms; end
                     default:  pend_ms <= step[11:4];
                  endcase
               end else begin
                  cnt <= cnt + 4'd1;
                  bcd <= step;
                  sh  <= {sh[8:0], 1'b0};
               end
            end
            COMMIT: begin
               {min_t, min_o} <= pend_min;
               {sec_t, sec_o} <= pend_sec;
               {ms_h, ms_t}   <= pend_ms;
               mode           <= snap_mode;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      case (idx)
         2'd3:    digit = mode ? sec_t : min_t;
         2'd2:    digit = mode ? sec_o : min_o;
         2'd1:    digit = mode ? ms_h  : sec_t;
         default: digit = mode ? ms_t  : sec_o;
      endcase
      case (digit)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
      if (LEAD_BLANK != 0 && idx == 2'd3 && digit == 4'd0) seg = 7'b1111111;
      an = ~(4'b0001 << idx);
      dp = (idx != 2'd2);
   end

endmodule

// File: tb/tb_time_display_driver.sv
// Randomized and directed bench for time_display_driver against a frame-level model
// (cycle count -> scan position, integer /10 %10 digit arithmetic, 23-cycle commit delay).
module tb_time_display_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] time_ms = '0;
   logic [5:0] time_sec = '0, time_min = '0;
   logic       disp_mode = 1'b0;
   logic [6:0] seg, seg0;
   logic       dp, dp0, busy, busy0;
   logic [3:0] an, an0;
   logic [25:0] obs;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   time_display_driver #(.SCAN_DIV(8), .LEAD_BLANK(1)) u_dut (
      .clk_high_speed(clk), .rst_n(rst_n), .time_ms(time_ms), .time_sec(time_sec),
      .time_min(time_min), .disp_mode(disp_mode), .seg(seg), .dp(dp), .an(an), .conv_busy(busy));
   time_display_driver #(.SCAN_DIV(8), .LEAD_BLANK(0)) u_dut0 (
      .clk_high_speed(clk), .rst_n(rst_n), .time_ms(time_ms), .time_sec(time_sec),
      .time_min(time_min), .disp_mode(disp_mode), .seg(seg0), .dp(dp0), .an(an0), .conv_busy(busy0));

   assign obs = {seg, seg0, an, an0, dp, dp0, busy, busy0};

   // Model: digits 0..5 = min_t, min_o, sec_t, sec_o, ms_h, ms_t
   int m_cyc, m_cnt, m_mode, p_mode;
   int m_dig[6], p_dig[6];

   function automatic int clamp_ms(int v);
      return (v > 999) ? 999 : v;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_cyc <= 0; m_cnt <= 0; m_mode <= 0;
         m_dig <= '{default: 0};
      end else begin
         m_cyc <= m_cyc + 1;
         if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin m_dig <= p_dig; m_mode <= p_mode; end
         end else if (m_cyc % 32 == 31) begin
            p_dig[0] <= int'(time_min) / 10;  p_dig[1] <= int'(time_min) % 10;
            p_dig[2] <= int'(time_sec) / 10;  p_dig[3] <= int'(time_sec) % 10;
            p_dig[4] <= clamp_ms(int'(time_ms)) / 100;
            p_dig[5] <= (clamp_ms(int'(time_ms)) / 10) % 10;
            p_mode <= int'(disp_mode);
            m_cnt <= 23;
         end
      end
   end

   function automatic int m_idx();
      return (m_cyc / 8) % 4;
   endfunction

   function automatic logic [6:0] seg_of(int d);
      case (d)
         0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
         3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
         6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
         9: return 7'b0010000;  default: return 7'b1111111;
      endcase
   endfunction

   function automatic int exp_digit();
      int i;
      i = m_idx();
      if (m_mode == 0) return m_dig[3 - i];
      else             return (i >= 2) ? m_dig[5 - i] : m_dig[5 - i];
   endfunction

   function automatic logic [25:0] exp_vec();
      int i, d;
      logic [6:0] s, s1;
      logic [3:0] a;
      logic p, b;
      i = m_idx();
      d = (m_mode == 0) ? m_dig[3 - i] : m_dig[5 - i];
      s = seg_of(d);
      s1 = (i == 3 && d == 0) ? 7'b1111111 : s;
      a = ~(4'b0001 << i);
      p = (i != 2);
      b = (m_cnt != 0);
      return {s1, s, a, a, p, p, b, b};
   endfunction

   task automatic test_reset();
      logic [3:0] an_tab [4];
      an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      time_min = 6'd12; time_sec = 6'd34; time_ms = 10'd0; disp_mode = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (an !== 4'b1110 || seg !== 7'b1000000 || seg0 !== 7'b1000000 || dp !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state an=%b seg=%b seg0=%b dp=%b busy=%b want an=1110 seg=1000000 dp=1 busy=0",
                  an, seg, seg0, dp, busy);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_scan cyc=%0d got=%b want=%b", m_cyc, obs, exp_vec());
         end
         if (k % 8 == 0) begin
            checks++;
            if (an !== an_tab[k / 8]) begin
               errors++;
               $display("FAIL scan_step k=%0d an=%b want=%b", k, an, an_tab[k / 8]);
            end
         end
      end
   endtask

   task automatic test_conv_busy();
      int n;
      logic [6:0] want [4];
      want = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
      n = 0;
      while (!busy && n < 64) begin @(negedge clk); n++; end
      checks++;
      if (!busy || m_cnt != 23) begin
         errors++;
         $display("FAIL busy_start busy=%b model_cnt=%0d want busy=1 cnt=23", busy, m_cnt);
      end
      n = 0;
      while (busy && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (n != 23) begin
         errors++;
         $display("FAIL busy_len got=%0d want=23", n);
      end
      for (int k = 0; k < 31; k++) begin
         checks++;
         if (obs !== exp_vec() || seg !== want[m_idx()] || dp !== (m_idx() != 2)) begin
            errors++;
            $display("FAIL show_1234 idx=%0d got=%b seg=%b want=%b/%b", m_idx(), obs, seg, exp_vec(), want[m_idx()]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_lead_blank();
      int n;
      logic [6:0] want [4];
      want = '{7'b1111000, 7'b1000000, 7'b0010010, 7'b1000000};
      time_min = 6'd5; time_sec = 6'd7;
      n = 0;
      while (m_cnt != 23 && n < 40) begin @(negedge clk); n++; end
      while (m_cnt != 0 && n < 80) begin @(negedge clk); n++; end
      checks++;
      if (n >= 80) begin errors++; $display("FAIL blank_timeout n=%0d", n); end
      for (int k = 0; k < 31; k++) begin
         checks++;
         if (obs !== exp_vec() || seg0 !== want[m_idx()] ||
             seg !== ((m_idx() == 3) ? 7'b1111111 : want[m_idx()])) begin
            errors++;
            $display("FAIL lead_blank idx=%0d seg=%b seg0=%b got=%b want=%b", m_idx(), seg, seg0, obs, exp_vec());
         end
         @(negedge clk);
      end
   endtask

   task automatic test_mode1();
      int n;
      logic [6:0] want [4];
      for (int pass = 0; pass < 2; pass++) begin
         time_sec = 6'd59; disp_mode = 1'b1;
         time_ms = (pass == 0) ? 10'd987 : 10'd1023;
         want = '{(pass == 0) ? 7'b0000000 : 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010010};
         n = 0;
         while (m_cnt != 23 && n < 40) begin @(negedge clk); n++; end
         while (m_cnt != 0 && n < 80) begin @(negedge clk); n++; end
         checks++;
         if (n >= 80) begin errors++; $display("FAIL mode1_timeout pass=%0d", pass); end
         for (int k = 0; k < 31; k++) begin
            checks++;
            if (obs !== exp_vec() || seg !== want[m_idx()] || dp !== (m_idx() != 2)) begin
               errors++;
               $display("FAIL mode1 pass=%0d idx=%0d seg=%b dp=%b want seg=%b got=%b model=%b",
                        pass, m_idx(), seg, dp, want[m_idx()], obs, exp_vec());
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_ignore_inputs();
      int n;
      logic [6:0] want [4];
      want = '{7'b1111000, 7'b1111001, 7'b0100100, 7'b0011001};
      time_min = 6'd42; time_sec = 6'd17; time_ms = 10'd0; disp_mode = 1'b0;
      n = 0;
      while (m_cnt != 23 && n < 40) begin @(negedge clk); n++; end
      time_min = 6'd33; time_sec = 6'd50;
      while (m_cnt != 12 && n < 80) begin @(negedge clk); n++; end
      disp_mode = 1'b1;
      while (m_cnt != 0 && n < 80) begin @(negedge clk); n++; end
      checks++;
      if (n >= 80) begin errors++; $display("FAIL ignore_timeout n=%0d", n); end
      for (int k = 0; k < 31; k++) begin
         checks++;
         if (obs !== exp_vec() || seg !== want[m_idx()]) begin
            errors++;
            $display("FAIL snapshot_hold idx=%0d seg=%b want=%b got=%b model=%b", m_idx(), seg, want[m_idx()], obs, exp_vec());
         end
         @(negedge clk);
      end
      // Next commit brings in mode 1 with the later inputs: 50.00
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL mode_switch cyc=%0d got=%b want=%b", m_cyc, obs, exp_vec());
         end
         @(negedge clk);
      end
      checks++;
      if (m_mode != 1 || (m_idx() == 3 && seg !== 7'b0010010)) begin
         errors++;
         $display("FAIL mode_after_commit model_mode=%0d seg=%b", m_mode, seg);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      time_min = 6'd59; time_sec = 6'd58; time_ms = 10'd876; disp_mode = 1'b0;
      n = 0;
      while (!(busy && m_cnt == 23) && n < 64) begin @(negedge clk); n++; end
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      time_min = 6'd0; time_sec = 6'd0; time_ms = 10'd0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || busy0 !== 1'b0 || seg0 !== 7'b1000000 || an !== 4'b1110) begin
         errors++;
         $display("FAIL reset_mid busy=%b seg0=%b an=%b want busy=0 seg0=1000000 an=1110", busy, seg0, an);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 70; k++) begin
         @(negedge clk);
         checks++;
         if (obs !== exp_vec() || seg0 !== 7'b1000000) begin
            errors++;
            $display("FAIL abort_hidden cyc=%0d seg0=%b got=%b want=%b", m_cyc, seg0, obs, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 12; it++) begin
         time_min  = 6'($urandom_range(0, 63));
         time_sec  = 6'($urandom_range(0, 63));
         time_ms   = 10'($urandom_range(0, 1023));
         disp_mode = 1'($urandom_range(0, 1));
         for (int k = 0; k < int'($urandom_range(5, 60)); k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
               errors++;
               $display("FAIL random it=%0d cyc=%0d got=%b want=%b", it, m_cyc, obs, exp_vec());
            end
         end
      end
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL random_tail cyc=%0d got=%b want=%b", m_cyc, obs, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_conv_busy();
      test_lead_blank();
      test_mode1();
      test_ignore_inputs();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
